clk_divider_bank: RTL and testbench
===================================

// Module: clk_divider_bank
// PURPOSE
//  Bank of NUM_CH independent programmable clock dividers driven from clk_in.
//  Per channel: 50%-duty divided clock (clk_out) plus a one-cycle tick strobe per half-period.
//  Divisor is reprogrammed at run time via a valid/ready load port and applied glitch-free.
//  Feeds the countdown/display logic: e.g. 1 Hz count tick, display-scan rate, blink rate.
// PARAMETERS
//  NUM_CH       4         number of divider channels (1..16)
//  DIV_W        32        width of divisor and per-channel counter
//  DEFAULT_DIV  50000000  divisor loaded into every channel at reset (must fit DIV_W)
//  CH_W         $clog2(NUM_CH>1?NUM_CH:2)  channel-index width (localparam, derived)
// PORTS
//  clk_in       in   1          system clock
//  rst          in   1          asynchronous reset, active high
//  en           in   NUM_CH     per-channel run enable
//  load_valid   in   1          divisor load request
//  load_ch      in   CH_W       target channel of load
//  load_div     in   DIV_W      new divisor value
//  load_ready   out  1          load accepted when load_valid & load_ready at posedge clk_in
//  pending      out  NUM_CH     channel holds an accepted, not yet applied divisor
//  clk_out      out  NUM_CH     divided clocks, registered
//  tick         out  NUM_CH     one-clk_in-cycle strobe coincident with each clk_out toggle
// BEHAVIOUR
//  Reset (async, rst=1): cnt=0, div=DEFAULT_DIV, pend_div=0, pending=0, clk_out=0, tick=0.
//  Counting (en[i]=1): cnt counts 0..div; cycle after cnt==div: cnt=0, clk_out[i] toggles,
//   tick[i]=1 for exactly that cycle. clk_out period = 2*(div+1) clk_in cycles; tick period = div+1.
//  div=0: clk_out toggles every cycle (clk_in/2), tick held high continuously.
//  Disable (en[i]=0): next edge cnt=0, clk_out[i]=0, tick[i]=0; held there while disabled.
//  Re-enable: counting restarts from 0; first toggle/tick after div+1 enabled cycles.
//  load_ready = !pending[load_ch] when load_ch<NUM_CH; 1 when load_ch>=NUM_CH.
//   Combinational from registered pending and load_ch only; never depends on load_valid.
//  Accept: pend_div[load_ch]=load_div, pending[load_ch]=1 on next edge.
//   load_ch>=NUM_CH: accepted and discarded, no state change.
//  Apply, channel enabled: at its terminal count (cnt==div) div=pend_div, cnt=0, pending=0.
//   The toggle/tick of that terminal count still occurs; new period starts immediately after.
//  Apply, channel disabled: div=pend_div, pending=0 on the cycle after acceptance.
//  Load accepted in same cycle as terminal count: goes pending, applied at the NEXT terminal count.
//  Load to a channel with pending=1: load_ready=0, request not accepted, must be held by source.
//  Channels fully independent; only the load port is shared (one load per cycle max).
//  rst asserted mid-period: all state returns to reset values immediately; pending loads lost.
//  Counter compare is equality only; div change never lets cnt exceed div (cnt cleared on apply).
// TESTING
//  (Bench: NUM_CH=4, DIV_W=8, DEFAULT_DIV=5.)
//  1 rst pulse then en=4'b1111 -> each clk_out toggles every 6 cycles (period 12); tick 1-cycle every 6.
//  2 en[1]=1, load ch1 div=2 mid-period -> pending[1]=1 until current terminal count,
//    then period 6 (tick every 3); other channels unchanged.
//  3 load ch2 div=0 while pending[2]=1 -> load_ready=0, held; after apply, accepted;
//    final clk_out[2]=clk_in/2, tick[2] stuck high.
//  4 en[3]=0, load ch3 div=9 -> pending[3] high one cycle, clk_out[3]=0;
//    en[3]=1 -> first tick after 10 cycles.
//  5 load_ch=3 with load_valid on ch3 terminal-count cycle -> old period completes once more,
//    new div applied next terminal count.
//  6 rst asserted between edges during counting with pending load -> outputs 0 immediately,
//    div back to 5, pending=0.

Source files
------------

// File: rtl/clk_divider_bank_if.sv
// Divisor load port shared by every channel of the divider bank.
// A load is accepted when load_valid and load_ready are both high at a clock edge.
interface clk_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 32
);
    localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

    logic             load_valid;
    logic [CH_W-1:0]  load_ch;
    logic [DIV_W-1:0] load_div;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_ch,
        output load_div,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_div,
        output load_ready
    );
endinterface

// File: rtl/clk_divider_bank.sv
// Bank of independent programmable 50%-duty clock dividers with per-channel tick strobes.
// New divisors wait in a one-deep buffer and take effect only at a period boundary.
module clk_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 32,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     en,
    clk_divider_bank_if.slave     load,
    output logic [NUM_CH-1:0]     pending,
    output logic [NUM_CH-1:0]     clk_out,
    output logic [NUM_CH-1:0]     tick
);
    localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

    logic [DIV_W-1:0] cnt      [NUM_CH];
    logic [DIV_W-1:0] div      [NUM_CH];
    logic [DIV_W-1:0] pend_div [NUM_CH];

    logic in_range;
    logic accept;

    // Out-of-range channel indices are always accepted so a stray request cannot stall the port.
    assign in_range = (32'(load.load_ch) < 32'(NUM_CH));
    assign accept   = load.load_valid && load.load_ready && in_range;

    always_comb begin
        load.load_ready = 1'b1;
        if (in_range) begin
            load.load_ready = !pending[load.load_ch];
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pending <= '0;
            clk_out <= '0;
            tick    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                div[i]      <= DIV_W'(DEFAULT_DIV);
                pend_div[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                    if (pending[i]) begin
                        div[i]     <= pend_div[i];
                        pending[i] <= 1'b0;
                    end
                end else if (cnt[i] == div[i]) begin
                    // Terminal count: toggle with the old divisor, then swap in any buffered one.
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    tick[i]    <= 1'b1;
                    if (pending[i]) begin
                        div[i]     <= pend_div[i];
                        pending[i] <= 1'b0;
                    end
                end else begin
                    cnt[i]  <= cnt[i] + DIV_W'(1);
                    tick[i] <= 1'b0;
                end

                // Acceptance requires pending low, so this never collides with the apply above.
                if (accept && (load.load_ch == CH_W'(i))) begin
                    pend_div[i] <= load.load_div;
                    pending[i]  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a period-level model.
module tb_clk_divider_bank;
    localparam int NCH = 4;

    logic       clk_in;
    logic       rst;
    logic [3:0] en;
    logic [3:0] pending;
    logic [3:0] clk_out;
    logic [3:0] tick;

    clk_divider_bank_if #(.NUM_CH(4), .DIV_W(8)) load_bus ();

    clk_divider_bank #(.NUM_CH(4), .DIV_W(8), .DEFAULT_DIV(5)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .load    (load_bus),
        .pending (pending),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int checks   = 0;
    int failures = 0;

    // Model: each channel runs periods of (div+1) enabled cycles; tracks cycles since period start.
    int m_elapsed [NCH];
    int m_div     [NCH];
    int m_pdiv    [NCH];
    bit m_pend    [NCH];
    bit m_clk     [NCH];
    bit m_tick    [NCH];
    bit last_accepted;

    function automatic logic [3:0] packBits(input bit b0, input bit b1, input bit b2, input bit b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            m_elapsed[i] = 0;
            m_div[i]     = 5;
            m_pdiv[i]    = 0;
            m_pend[i]    = 0;
            m_clk[i]     = 0;
            m_tick[i]    = 0;
        end
    endtask

    task automatic modelEdge();
        int ch;
        ch = int'(load_bus.load_ch);
        last_accepted = load_bus.load_valid && !m_pend[ch];
        for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 0;
            if (!en[i]) begin
                m_elapsed[i] = 0;
                m_clk[i]     = 0;
                if (m_pend[i]) begin
                    m_div[i]  = m_pdiv[i];
                    m_pend[i] = 0;
                end
            end else begin
                m_elapsed[i] = m_elapsed[i] + 1;
                if (m_elapsed[i] == m_div[i] + 1) begin
                    m_tick[i]    = 1;
                    m_clk[i]     = !m_clk[i];
                    m_elapsed[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i]  = m_pdiv[i];
                        m_pend[i] = 0;
                    end
                end
            end
        end
        if (last_accepted) begin
            m_pdiv[ch] = int'(load_bus.load_div);
            m_pend[ch] = 1;
        end
    endtask

    task automatic doCheck(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        doCheck({tag, "_clk_out"}, 8'(clk_out), 8'(packBits(m_clk[0], m_clk[1], m_clk[2], m_clk[3])));
        doCheck({tag, "_tick"},    8'(tick),    8'(packBits(m_tick[0], m_tick[1], m_tick[2], m_tick[3])));
        doCheck({tag, "_pending"}, 8'(pending), 8'(packBits(m_pend[0], m_pend[1], m_pend[2], m_pend[3])));
    endtask

    // One clock cycle: drive inputs, check load_ready, advance model and DUT, check outputs.
    task automatic applyStimulus(input string tag, input logic [3:0] e, input logic v,
                                 input logic [1:0] c, input logic [7:0] d);
        en                  = e;
        load_bus.load_valid = v;
        load_bus.load_ch    = c;
        load_bus.load_div   = d;
        #1;
        doCheck({tag, "_load_ready"}, 8'(load_bus.load_ready), 8'(!m_pend[int'(c)]));
        modelEdge();
        @(posedge clk_in);
        #1;
        checkOutput(tag);
    endtask

    task automatic runIdle(input string tag, input int n);
        for (int k = 0; k < n; k++) applyStimulus(tag, en, 1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        logic [3:0] ren;
        int guard;

        rst = 1'b1;
        en = 4'b0000;
        load_bus.load_valid = 1'b0;
        load_bus.load_ch    = 2'd0;
        load_bus.load_div   = 8'd0;
        modelReset();
        #2;
        checkOutput("reset");
        doCheck("reset_load_ready", 8'(load_bus.load_ready), 8'd1);
        @(posedge clk_in);
        #2;
        rst = 1'b0;

        // All channels at the default divisor.
        en = 4'b1111;
        runIdle("s1_default", 14);

        // Reprogram channel 1 mid-period.
        applyStimulus("s2_load", en, 1'b1, 2'd1, 8'd2);
        runIdle("s2_run", 15);

        // Channel 2: second load must wait for the first to apply.
        applyStimulus("s3_load9", en, 1'b1, 2'd2, 8'd9);
        guard = 0;
        do begin
            applyStimulus("s3_hold", en, 1'b1, 2'd2, 8'd0);
            guard++;
        end while (!last_accepted && guard < 30);
        runIdle("s3_run", 20);

        // Channel 3 disabled: load applies immediately, restart counts from zero.
        applyStimulus("s4_dis", 4'b0111, 1'b0, 2'd0, 8'd0);
        applyStimulus("s4_load", 4'b0111, 1'b1, 2'd3, 8'd9);
        runIdle("s4_idle", 3);
        applyStimulus("s4_en", 4'b1111, 1'b0, 2'd0, 8'd0);
        runIdle("s4_run", 22);

        // Load landing exactly on channel 3's terminal-count cycle.
        guard = 0;
        while (m_elapsed[3] != m_div[3] && guard < 30) begin
            applyStimulus("s5_wait", en, 1'b0, 2'd0, 8'd0);
            guard++;
        end
        applyStimulus("s5_load", en, 1'b1, 2'd3, 8'd3);
        runIdle("s5_run", 25);

        // Random enables and loads.
        for (int k = 0; k < 300; k++) begin
            ren = en;
            if ($urandom_range(0, 19) == 0) ren[$urandom_range(0, 3)] = ~ren[$urandom_range(0, 3) & 0 | 0] | 1'b0;
            if ($urandom_range(0, 24) == 0) ren = 4'($urandom_range(0, 15));
            applyStimulus("rand", ren, 1'($urandom_range(0, 99) < 30),
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)));
        end

        // Mid-period reset with a load still pending.
        en = 4'b1111;
        applyStimulus("s6_pre", en, 1'b1, 2'd0, 8'd7);
        #3;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("s6_async");
        doCheck("s6_load_ready", 8'(load_bus.load_ready), 8'd1);
        @(posedge clk_in);
        #2;
        rst = 1'b0;
        runIdle("s6_run", 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
